// File: rtl/dds_ctrl.sv
//==============================================================================
// Module  : dds_ctrl
// Brief   : Byte-command controller that loads the 512-entry waveform table,
//           sets the DA clock divider and address step, and plays the table
//           out to an 8-bit DA as inverted samples.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module dds_ctrl #(
  parameter int unsigned DIV_RST  = 24,
  parameter int unsigned STEP_RST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       ram_we,
  output logic [8:0] ram_waddr,
  output logic [7:0] ram_wdata,
  output logic [8:0] ram_raddr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] da_data,
  output logic       da_clk,
  output logic       running,
  output logic       wrap,
  output logic       cmd_err
);

  localparam logic [1:0] S_CMD  = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_DIV   = 8'h02;
  localparam logic [7:0] OP_START = 8'h03;
  localparam logic [7:0] OP_STOP  = 8'h04;
  localparam logic [7:0] OP_STEP  = 8'h05;

  localparam logic [7:0] C_DIV_RST  = 8'(DIV_RST);
  localparam logic [7:0] C_STEP_RST = 8'(STEP_RST);

  logic [1:0] state_q, state_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic       ready_q, ready_d;
  logic       we_q, we_d;
  logic [8:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [8:0] raddr_q, raddr_d;
  logic [7:0] da_data_q, da_data_d;
  logic       da_clk_q, da_clk_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       err_q, err_d;
  logic [7:0] div_q, div_d;
  logic [7:0] step_q, step_d;
  logic [7:0] dcnt_q, dcnt_d;

  logic       accept;
  logic [9:0] addr_sum;

  assign accept   = cmd_valid & ready_q;
  assign addr_sum = {1'b0, raddr_q} + {2'b00, step_q};

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ready_d   = 1'b1;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    da_data_d = da_data_q;
    da_clk_d  = da_clk_q;
    running_d = running_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    div_d     = div_q;
    step_d    = step_q;
    dcnt_d    = dcnt_q;

    if (running_q) begin
      if (dcnt_q >= div_q) begin
        dcnt_d   = 8'd0;
        da_clk_d = ~da_clk_q;
        // Falling edge: latch the sample addressed last period, then advance.
        if (da_clk_q) begin
          da_data_d = 8'hFF - ram_rdata;
          raddr_d   = addr_sum[8:0];
          wrap_d    = addr_sum[9];
        end
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end
    end

    if (accept) begin
      case (state_q)
        S_CMD: begin
          case (cmd_data)
            OP_LOAD, OP_STOP: begin
              running_d = 1'b0;
              da_clk_d  = 1'b0;
              dcnt_d    = 8'd0;
              da_data_d = da_data_q;
              raddr_d   = raddr_q;
              wrap_d    = 1'b0;
              if (cmd_data == OP_LOAD) begin
                state_d = S_LOAD;
                wcnt_d  = 9'd0;
              end
            end
            OP_START: begin
              running_d = 1'b1;
              da_clk_d  = 1'b0;
              dcnt_d    = 8'd0;
              raddr_d   = 9'd0;
              da_data_d = da_data_q;
              wrap_d    = 1'b0;
            end
            OP_DIV:  state_d = S_DIV;
            OP_STEP: state_d = S_STEP;
            default: err_d = 1'b1;
          endcase
        end
        S_LOAD: begin
          we_d    = 1'b1;
          waddr_d = wcnt_q;
          wdata_d = cmd_data;
          wcnt_d  = wcnt_q + 9'd1;
          if (wcnt_q == 9'd511) begin
            state_d = S_CMD;
          end
        end
        S_DIV: begin
          div_d   = cmd_data;
          state_d = S_CMD;
        end
        default: begin
          step_d  = cmd_data;
          state_d = S_CMD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CMD;
      wcnt_q    <= 9'd0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= 9'd0;
      wdata_q   <= 8'd0;
      raddr_q   <= 9'd0;
      da_data_q <= 8'h00;
      da_clk_q  <= 1'b0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      div_q     <= C_DIV_RST;
      step_q    <= C_STEP_RST;
      dcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      da_data_q <= da_data_d;
      da_clk_q  <= da_clk_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      div_q     <= div_d;
      step_q    <= step_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign cmd_ready = ready_q;
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign ram_raddr = raddr_q;
  assign da_data   = da_data_q;
  assign da_clk    = da_clk_q;
  assign running   = running_q;
  assign wrap      = wrap_q;
  assign cmd_err   = err_q;

endmodule

`default_nettype wire

// File: doc/dds_ctrl.md
# dds_ctrl

Command-driven controller for the waveform DA output path. It accepts a byte command stream from the host interface and loads the 512-entry waveform table through its write port. It programs the DA clock divider and address step, starts and stops playback, and reads the table to drive the 8-bit DA with inverted samples that change on the DA clock's falling edge. It sits between the host byte link and the waveform RAM/DA pins, replacing free-running DDS sequencing.

## Interface
Parameters:
- DIV_RST, 24: divider value after reset; DA clock half-period = div+1 clk cycles.
- STEP_RST, 1: address step after reset.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host byte valid.
- cmd_data  in  8  host byte.
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready.
- ram_we  out  1  table write strobe.
- ram_waddr  out  9  table write address.
- ram_wdata  out  8  table write data.
- ram_raddr  out  9  table read address; synchronous RAM, 1-cycle read latency.
- ram_rdata  in  8  table read data.
- da_data  out  8  DA sample = 8'hFF - table value.
- da_clk  out  1  DA write clock.
- running  out  1  playback active.
- wrap  out  1  one-cycle pulse when the read address wraps past 511.
- cmd_err  out  1  one-cycle pulse on an unknown opcode.

## Operation
- Opcodes: 0x01 LOAD (+512 data bytes), 0x02 SET_DIV (+1 byte), 0x03 START, 0x04 STOP, 0x05 SET_STEP (+1 byte). Any other opcode: byte dropped, cmd_err pulses, FSM stays in CMD.
- FSM states: CMD, LOAD, DIV_ARG, STEP_ARG.
  - CMD -> LOAD on 0x01.
  - CMD -> DIV_ARG on 0x02.
  - CMD -> STEP_ARG on 0x05.
  - 0x03 and 0x04 act in CMD and stay in CMD.
  - LOAD -> CMD after the 512th data byte.
  - DIV_ARG and STEP_ARG -> CMD after one byte.
- LOAD:
  - Accepting the opcode clears running (same as STOP) and zeroes the write counter.
  - Each accepted data byte drives ram_we=1, ram_waddr=counter, ram_wdata=byte in the following cycle; counter then increments.
  - ram_we is 0 whenever no byte is being written.
- cmd_ready = 1 in every state when out of reset; one byte per cycle is accepted.
- START:
  - Sets running=1.
  - Zeroes ram_raddr, the divider counter and da_clk.
  - START while already running restarts the same way.
- STOP: running=0, da_clk=0, divider counter=0. da_data holds its last value. ram_raddr holds its value.
- Divider, while running:
  - If counter >= div: counter <= 0 and da_clk toggles.
  - Otherwise counter increments.
  - A new div takes effect on the next compare. If the counter is already >= new div, the toggle occurs on the next cycle.
- Falling-edge action (the cycle da_clk is registered 1->0):
  - da_data <= 8'hFF - ram_rdata.
  - ram_raddr <= (ram_raddr + step) mod 512, using a 9-bit sum with carry discarded.
  - wrap pulses in the same cycle if ram_raddr + step >= 512.
- step = 0 is legal: the same sample repeats and wrap never pulses. A new step applies at the next falling edge.
- The RAM contents are not reset. The table retains partial loads.

## Timing
- Reset values:
  - cmd_ready=0, ram_we=0, ram_waddr=0, ram_wdata=0, ram_raddr=0.
  - da_data=8'h00, da_clk=0, running=0, wrap=0, cmd_err=0.
  - FSM=CMD, div=DIV_RST, step=STEP_RST.
  - cmd_ready rises on the first clk after reset release.
- Reset asserted mid-LOAD or mid-argument: immediate return to reset state; the remaining bytes are reinterpreted as opcodes.
- Command latency:
  - running changes 1 cycle after START/STOP acceptance.
  - cmd_err pulses 1 cycle after a bad opcode.
  - ram_we appears 1 cycle after a data byte.
- Playback from START accepted at cycle T:
  - da_clk rises at T+1+(div+1).
  - da_clk falls at T+1+2(div+1); da_data updates to 8'hFF - table[0] in that same cycle.
  - The first table read is valid 1 cycle after raddr is set, and is ready for any div >= 0.
- DA period = 2(div+1) clk cycles. Default: 50 cycles.

## Test plan
- Reset then LOAD with table[i]=i[7:0], START, default div -> da_clk period 50 cycles; da_data sequence 0xFF, 0xFE, 0xFD...; wrap pulses once per 512 falling edges.
- SET_DIV 0, SET_STEP 3, START -> da_clk period 2 cycles; samples from addresses 0, 3, 6, ..., 510, then 1 (wrap pulse on the 510->1 transition).
- STOP mid-playback -> da_clk=0 next cycle; da_data frozen; START -> first new sample is 8'hFF - table[0].
- Opcode 0x7E -> single cmd_err pulse; the following 0x03 starts playback normally.
- LOAD opcode while running -> running=0; exactly 512 ram_we pulses with addresses 0..511; the byte after the 512th is decoded as an opcode.
- Reset asserted after 100 LOAD bytes -> all outputs at reset values; the next byte 0x03 is treated as START.
